fpu_operand_master: RTL and testbench
=====================================

FPU_OPERAND_MASTER -- requirements
Module: fpu_operand_master

Interface
REQ-001 The block SHALL take parameter TIMEOUT, default 1024, as the maximum cycles to wait for any single handshake before aborting.
REQ-002 The block SHALL take parameter FIFO_DEPTH, default 4, as the number of result FIFO entries (power of two, at least 2).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have the following ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  operand pair offered
- cmd_ready  out  1  operand pair accepted when high with cmd_valid
- cmd_a  in  32  operand A
- cmd_b  in  32  operand B
- fpu_a  out  32  operand A to FPU
- fpu_a_stb  out  1  operand A valid
- fpu_a_ack  in  1  FPU accepts A
- fpu_b  out  32  operand B to FPU
- fpu_b_stb  out  1  operand B valid
- fpu_b_ack  in  1  FPU accepts B
- fpu_z  in  32  FPU result
- fpu_z_stb  in  1  FPU result valid
- fpu_z_ack  out  1  block accepts result
- res_valid  out  1  result FIFO not empty
- res_ready  in  1  consumer pops head
- res_data  out  32  head result word
- res_err  out  1  head entry was produced by a timeout
- busy  out  1  a transaction is in flight (state not IDLE)

Function
REQ-005 The block SHALL count a transfer on any stb/ack channel only in a cycle where stb and ack are both high at a rising clk edge.
REQ-006 The block SHALL implement the states IDLE, SEND_A, SEND_B and WAIT_Z, with only one transaction in flight.
REQ-007 The block SHALL drive cmd_ready = (state==IDLE) && FIFO not full, combinationally from registered state.
- On a cmd transfer, it SHALL latch cmd_a into fpu_a and cmd_b into fpu_b, and move to SEND_A.
REQ-008 In SEND_A the block SHALL hold fpu_a_stb=1 with fpu_a stable.
- On an A transfer, next cycle fpu_a_stb=0 and state=SEND_B.
REQ-009 In SEND_B the block SHALL hold fpu_b_stb=1 with fpu_b stable.
- On a B transfer, next cycle fpu_b_stb=0 and state=WAIT_Z.
REQ-010 In WAIT_Z the block SHALL hold fpu_z_ack=1.
- On a Z transfer, it SHALL push {err=0, fpu_z} into the FIFO, and next cycle fpu_z_ack=0 and state=IDLE.
REQ-011 All stb and ack outputs SHALL be registered, and SHALL never be high outside their own state.
REQ-012 Latency: cmd transfer at cycle 0; fpu_a_stb high at 1; fpu_b_stb high at 2 (A acked at 1); fpu_z_ack high at 3; res_valid high at 4 if fpu_z_stb is high at 3.
REQ-013 A wait counter SHALL clear on entry to SEND_A, SEND_B and WAIT_Z, and SHALL increment each cycle that state's handshake does not complete.
REQ-014 When the counter equals TIMEOUT-1 without a transfer in that cycle, the block SHALL:
- push {err=1, 32'h7FC00000};
- drop all stb and ack outputs next cycle;
- return to IDLE.
REQ-015 A transfer in the same cycle as the timeout condition SHALL take priority; no error entry is pushed.
REQ-016 The FIFO SHALL be a circular buffer with wrapping read and write pointers and a count of width log2(FIFO_DEPTH)+1.
- res_data and res_err SHALL show the head entry whenever res_valid=1.
REQ-017 A pop (res_valid && res_ready) and a push in the same cycle SHALL leave the count unchanged and preserve ordering.
REQ-018 A push SHALL never occur with the FIFO full; this is guaranteed by REQ-007, and an assertion SHALL check it.
REQ-019 Pops with res_valid=0 SHALL be ignored.
REQ-020 busy SHALL be 1 in SEND_A, SEND_B and WAIT_Z, and 0 in IDLE.

Reset
REQ-021 While rst_n=0, independent of clk, the block SHALL hold:
- state=IDLE;
- fpu_a_stb, fpu_b_stb, fpu_z_ack, res_valid, res_err and busy at 0;
- fpu_a, fpu_b and res_data at 0;
- FIFO pointers, count and wait counter at 0.
REQ-022 A reset asserted mid-transaction SHALL abandon it without pushing any entry.
- cmd_ready SHALL rise on the first clk edge after rst_n deasserts.

Verification
REQ-023 Nominal: cmd_a=0x40400000, cmd_b=0x3F800000, responder acks immediately and returns fpu_z=0x40400000 at cycle 3 -> res_valid=1 at cycle 4, res_data=0x40400000, res_err=0.
REQ-024 Backpressure: res_ready=0, four back-to-back commands with an immediate responder -> count=4, cmd_ready=0; a fifth cmd_valid stays unaccepted until one pop.
REQ-025 Timeout: TIMEOUT=16, fpu_a_ack tied 0 -> fpu_a_stb high for exactly 16 cycles, then res_data=0x7FC00000, res_err=1, busy=0.
REQ-026 Race: TIMEOUT=16, fpu_z_stb raised on the 16th WAIT_Z cycle -> normal entry with err=0, no error entry.
REQ-027 Reset mid-WAIT_Z: rst_n pulsed low for 1 cycle -> all outputs 0 immediately, FIFO empty, cmd_ready=1 after release.
REQ-028 Simultaneous push/pop: count=2 with pop and push in the same cycle -> count stays 2; the order of returned results matches command order.

Source files
------------

// File: rtl/fpu_operand_master.sv
// rtl/fpu_operand_master.sv - sequences operand pairs into a strobe/ack FPU and queues its results
`timescale 1ns/1ps

module fpu_operand_master #(
    parameter int TIMEOUT    = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic [31:0] fpu_a,
    output logic        fpu_a_stb,
    input  logic        fpu_a_ack,
    output logic [31:0] fpu_b,
    output logic        fpu_b_stb,
    input  logic        fpu_b_ack,
    input  logic [31:0] fpu_z,
    input  logic        fpu_z_stb,
    output logic        fpu_z_ack,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_err,
    output logic        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [31:0]   ERR_WORD  = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, SEND_A, SEND_B, WAIT_Z} state_t;

    state_t          state, state_nxt;
    logic            a_stb_q, b_stb_q, z_ack_q;
    logic            a_stb_d, b_stb_d, z_ack_d;
    logic            live;
    logic [CW-1:0]   wait_cnt;
    logic [31:0]     a_q, b_q;
    logic [31:0]     mem_data [FIFO_DEPTH];
    logic            mem_err  [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            full, cmd_xfer, a_xfer, b_xfer, z_xfer, hs_done;
    logic            timeout_hit, push, pop;

    // live stays low through reset so cmd_ready only rises on the first edge after release
    assign full      = (count == FULL_CNT);
    assign cmd_ready = live && (state == IDLE) && !full;
    assign busy      = (state != IDLE);
    assign cmd_xfer  = cmd_valid && cmd_ready;
    assign a_xfer    = a_stb_q && fpu_a_ack;
    assign b_xfer    = b_stb_q && fpu_b_ack;
    assign z_xfer    = z_ack_q && fpu_z_stb;
    assign hs_done   = a_xfer || b_xfer || z_xfer;
    assign timeout_hit = (state != IDLE) && (wait_cnt == WAIT_LAST) && !hs_done;
    assign push      = z_xfer || timeout_hit;
    assign pop       = res_valid && res_ready;

    assign fpu_a     = a_q;
    assign fpu_b     = b_q;
    assign fpu_a_stb = a_stb_q;
    assign fpu_b_stb = b_stb_q;
    assign fpu_z_ack = z_ack_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_stb_q <= 1'b0;
            b_stb_q <= 1'b0;
            z_ack_q <= 1'b0;
            live    <= 1'b0;
        end else begin
            state   <= state_nxt;
            a_stb_q <= a_stb_d;
            b_stb_q <= b_stb_d;
            z_ack_q <= z_ack_d;
            live    <= 1'b1;
        end
    end

    // A completed handshake wins over a timeout landing in the same cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_xfer) state_nxt = SEND_A;
            SEND_A:  if (a_xfer) state_nxt = SEND_B;
                     else if (timeout_hit) state_nxt = IDLE;
            SEND_B:  if (b_xfer) state_nxt = WAIT_Z;
                     else if (timeout_hit) state_nxt = IDLE;
            WAIT_Z:  if (z_xfer || timeout_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        a_stb_d = (state_nxt == SEND_A);
        b_stb_d = (state_nxt == SEND_B);
        z_ack_d = (state_nxt == WAIT_Z);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if ((state_nxt != state) || (state == IDLE)) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else if (cmd_xfer) begin
            a_q <= cmd_a;
            b_q <= cmd_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= timeout_hit ? ERR_WORD : fpu_z;
            mem_err[wr_ptr]  <= timeout_hit;
        end
    end

    assign res_valid = (count != '0);
    assign res_data  = res_valid ? mem_data[rd_ptr] : '0;
    assign res_err   = res_valid && mem_err[rd_ptr];

    a_push_not_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: tb/tb_fpu_operand_master.sv
// tb/tb_fpu_operand_master.sv - directed and randomized bench against a result-queue model
`timescale 1ns/1ps

module tb_fpu_operand_master;

    localparam int TIMEOUT = 16;
    localparam int DEPTH   = 4;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic        clk = 1'b0;
    logic        rst_n, cmd_valid, cmd_ready, fpu_a_stb, fpu_a_ack, fpu_b_stb, fpu_b_ack;
    logic        fpu_z_stb, fpu_z_ack, res_valid, res_ready, res_err, busy;
    logic [31:0] cmd_a, cmd_b, fpu_a, fpu_b, fpu_z, res_data;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } entry_t;

    entry_t exp_q[$];
    int     tests = 0;
    int     fails = 0;

    always #5 clk = ~clk;

    fpu_operand_master #(.TIMEOUT(TIMEOUT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .fpu_a(fpu_a), .fpu_a_stb(fpu_a_stb), .fpu_a_ack(fpu_a_ack),
        .fpu_b(fpu_b), .fpu_b_stb(fpu_b_stb), .fpu_b_ack(fpu_b_ack),
        .fpu_z(fpu_z), .fpu_z_stb(fpu_z_stb), .fpu_z_ack(fpu_z_ack),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_err(res_err), .busy(busy)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic entry_t mk(input logic err, input logic [31:0] data);
        entry_t e;
        e.err  = err;
        e.data = data;
        return e;
    endfunction

    function automatic logic chan_hi(input int which);
        case (which)
            0:       return fpu_a_stb;
            1:       return fpu_b_stb;
            default: return fpu_z_ack;
        endcase
    endfunction

    task automatic drive(input int which, input logic v);
        case (which)
            0:       fpu_a_ack = v;
            1:       fpu_b_ack = v;
            default: fpu_z_stb = v;
        endcase
    endtask

    task automatic check_head_pop();
        entry_t e;
        e = exp_q.pop_front();
        chk1("head_valid", res_valid, 1'b1);
        chk32("head_data", res_data, e.data);
        chk1("head_err", res_err, e.err);
        res_ready = 1'b1;
    endtask

    task automatic pop_one();
        check_head_pop();
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic start_cmd(input logic [31:0] a, input logic [31:0] b, output bit ok);
        int n = 0;
        cmd_a = a;
        cmd_b = b;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk1("cmd_accept", cmd_ready, 1'b1);
        ok = (cmd_ready === 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        if (ok) begin
            chk32("fpu_a_word", fpu_a, a);
            chk1("busy_on", busy, 1'b1);
        end
    endtask

    // The responder answers on cycle index lat of the phase; a phase completes iff lat < TIMEOUT
    task automatic phase(input int which, input int lat, input bit pop_now, output bit ok);
        int hi = 0;
        ok = (lat < TIMEOUT);
        for (int c = 0; c < TIMEOUT + 4; c++) begin
            if (chan_hi(which) !== 1'b1) break;
            hi++;
            if (c == lat) begin
                drive(which, 1'b1);
                if (pop_now) check_head_pop();
            end
            @(negedge clk);
            drive(which, 1'b0);
            res_ready = 1'b0;
            if (c == lat) break;
        end
        chk32("stb_cycles", 32'(hi), ok ? 32'(lat + 1) : 32'(TIMEOUT));
        chk1("stb_drop", chan_hi(which), 1'b0);
    endtask

    task automatic txn(input logic [31:0] a, input logic [31:0] b, input logic [31:0] z,
                       input int la, input int lb, input int lz, input bit pop_z);
        bit ok;
        start_cmd(a, b, ok);
        if (!ok) return;
        phase(0, la, 1'b0, ok);
        if (ok) begin
            chk32("fpu_b_word", fpu_b, b);
            phase(1, lb, 1'b0, ok);
            if (ok) begin
                fpu_z = z;
                phase(2, lz, pop_z, ok);
            end
        end
        exp_q.push_back(ok ? mk(1'b0, z) : mk(1'b1, QNAN));
        chk1("busy_off", busy, 1'b0);
    endtask

    function automatic int pick_lat();
        int r = int'($urandom % 8);
        if (r < 5) return r % 4;
        return 14 + int'($urandom % 4);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        bit ok;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0;
        fpu_a_ack = 1'b0; fpu_b_ack = 1'b0; fpu_z = '0; fpu_z_stb = 1'b0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk1("rst_cmd_ready", cmd_ready, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_res_valid", res_valid, 1'b0);
        chk32("rst_fpu_a", fpu_a, 32'h0);
        chk32("rst_res_data", res_data, 32'h0);
        rst_n = 1'b1;
        #1 chk1("ready_before_edge", cmd_ready, 1'b0);
        @(negedge clk);
        chk1("ready_after_edge", cmd_ready, 1'b1);

        // nominal: result visible on cycle 4
        txn(32'h4040_0000, 32'h3F80_0000, 32'h4040_0000, 0, 0, 0, 1'b0);
        pop_one();
        chk1("empty_after_nominal", res_valid, 1'b0);

        // pop on empty FIFO is ignored
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk1("empty_pop_ignored", res_valid, 1'b0);
        txn($urandom, $urandom, 32'h1234_5678, 1, 2, 3, 1'b0);
        pop_one();

        // backpressure: four results fill the FIFO and block the fifth command
        for (int i = 0; i < DEPTH; i++) txn($urandom, $urandom, $urandom, 0, 0, 0, 1'b0);
        chk1("full_cmd_ready", cmd_ready, 1'b0);
        cmd_valid = 1'b1;
        repeat (4) @(negedge clk);
        chk1("full_blocked_busy", busy, 1'b0);
        chk1("full_blocked_ready", cmd_ready, 1'b0);
        pop_one();
        txn($urandom, $urandom, $urandom, 0, 0, 0, 1'b0);
        while (exp_q.size() > 0) pop_one();
        chk1("drained", res_valid, 1'b0);

        // timeouts and same-cycle races at every phase boundary
        txn($urandom, $urandom, $urandom, 100, 0, 0, 1'b0);
        pop_one();
        txn($urandom, $urandom, 32'hCAFE_0001, 0, 0, TIMEOUT - 1, 1'b0);
        pop_one();
        txn($urandom, $urandom, 32'hCAFE_0002, TIMEOUT - 1, TIMEOUT - 1, 0, 1'b0);
        txn($urandom, $urandom, $urandom, 0, TIMEOUT, 0, 1'b0);
        txn($urandom, $urandom, $urandom, 0, 0, TIMEOUT, 1'b0);
        while (exp_q.size() > 0) pop_one();

        // push and pop in the same cycle with two entries queued
        txn($urandom, $urandom, 32'hA000_0001, 0, 0, 0, 1'b0);
        txn($urandom, $urandom, 32'hA000_0002, 0, 0, 0, 1'b0);
        txn($urandom, $urandom, 32'hA000_0003, 0, 0, 2, 1'b1);
        chk32("count_after_pushpop", 32'(exp_q.size()), 32'd2);
        pop_one();
        pop_one();
        chk1("empty_after_pushpop", res_valid, 1'b0);

        // reset pulse in WAIT_Z with an entry already queued
        txn($urandom, $urandom, $urandom, 0, 0, 0, 1'b0);
        start_cmd(32'h1111_1111, 32'h2222_2222, ok);
        phase(0, 0, 1'b0, ok);
        phase(1, 0, 1'b0, ok);
        chk1("in_wait_z", fpu_z_ack, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_z_ack", fpu_z_ack, 1'b0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_res_valid", res_valid, 1'b0);
        chk1("mid_rst_cmd_ready", cmd_ready, 1'b0);
        chk32("mid_rst_fpu_b", fpu_b, 32'h0);
        chk32("mid_rst_res_data", res_data, 32'h0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk1("rel_ready_before_edge", cmd_ready, 1'b0);
        @(negedge clk);
        chk1("rel_ready_after_edge", cmd_ready, 1'b1);
        chk1("rel_fifo_empty", res_valid, 1'b0);

        // randomized traffic
        for (int i = 0; i < 14; i++) begin
            if (exp_q.size() == DEPTH) pop_one();
            txn($urandom, $urandom, $urandom, pick_lat(), pick_lat(), pick_lat(),
                (exp_q.size() > 0) && ($urandom % 3 == 0));
            if (exp_q.size() > 0 && ($urandom % 2 == 0)) pop_one();
        end
        while (exp_q.size() > 0) pop_one();
        chk1("final_empty", res_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
